// File: rtl/sprite_renderer.sv
// Sprite renderer: walk animation state updated at vsync, mirrored
// ROM addressing and a three-stage hit/colour pipeline.
module sprite_renderer #(
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 32,
    parameter int ANIM_DIV   = 8,
    parameter int IDLE_FRAME = 8,
    parameter int WALK_BASE  = 8,
    parameter int ADDR_W     = 14
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic [7:0]        Keycode,
    input  logic [10:0]       spritex,
    input  logic [10:0]       spritey,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic              sprite_on,
    output logic [3:0]        pixel_idx,
    output logic [3:0]        anim_frame,
    output logic              facing_left
);

    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic {IDLE, WALK} state_t;

    state_t          state;
    state_t          state_nx;
    logic [DW-1:0]   div_cnt;
    logic [DW-1:0]   div_nx;
    logic [1:0]      walk_idx;
    logic [1:0]      walk_nx;
    logic            walk_key;

    logic [11:0]     dx;
    logic [11:0]     dy;
    logic [11:0]     sx;
    logic [11:0]     sy;
    logic            hit;
    logic [CW-1:0]   col;
    logic [CW-1:0]   col_m;
    logic [RW-1:0]   row;
    logic [ADDR_W-1:0] addr_nx;
    logic            hit_d1;
    logic            hit_d2;
    logic            opaque;

    assign walk_key = (Keycode == 8'd79) || (Keycode == 8'd80);

    // Animation state advances only on the vsync pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            walk_idx <= '0;
        end else if (frame_start) begin
            state    <= state_nx;
            div_cnt  <= div_nx;
            walk_idx <= walk_nx;
        end
    end

    // Next animation state: walk while an arrow key is held
    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        walk_nx  = walk_idx;
        unique case (state)
            IDLE: begin
                if (walk_key) begin
                    state_nx = WALK;
                    div_nx   = '0;
                    walk_nx  = '0;
                end
            end
            WALK: begin
                if (!walk_key) begin
                    state_nx = IDLE;
                    div_nx   = '0;
                    walk_nx  = '0;
                end else if (div_cnt == DW'(ANIM_DIV - 1)) begin
                    div_nx  = '0;
                    walk_nx = walk_idx + 2'd1;
                end else begin
                    div_nx = div_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Selected ROM frame follows the animation state
    always_comb begin
        anim_frame = 4'(IDLE_FRAME);
        if (state == WALK)
            anim_frame = 4'(WALK_BASE) + {2'b00, walk_idx};
    end

    // Facing direction latched at vsync; other keys keep it
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            facing_left <= 1'b0;
        else if (frame_start && Keycode == 8'd80)
            facing_left <= 1'b1;
        else if (frame_start && Keycode == 8'd79)
            facing_left <= 1'b0;
    end

    // Hit test in 12 bits so the far box edge never wraps
    always_comb begin
        dx    = {2'b00, DrawX};
        dy    = {2'b00, DrawY};
        sx    = {1'b0, spritex};
        sy    = {1'b0, spritey};
        hit   = (dx >= sx) && (dx < sx + 12'(SPRITE_W)) &&
                (dy >= sy) && (dy < sy + 12'(SPRITE_H));
        col   = DrawX[CW-1:0] - spritex[CW-1:0];
        row   = DrawY[RW-1:0] - spritey[RW-1:0];
        col_m = facing_left ? ~col : col;
        addr_nx = ADDR_W'({anim_frame, row, col_m});
    end

    assign opaque = hit_d2 && (rom_data != 4'd0);

    // Three-stage pipeline: address, ROM read, colour
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr  <= '0;
            hit_d1    <= 1'b0;
            hit_d2    <= 1'b0;
            sprite_on <= 1'b0;
            pixel_idx <= 4'd0;
        end else begin
            if (hit)
                rom_addr <= addr_nx;
            hit_d1    <= hit;
            hit_d2    <= hit_d1;
            sprite_on <= opaque;
            pixel_idx <= opaque ? rom_data : 4'd0;
        end
    end

endmodule

// File: tb/tb_sprite_renderer.sv
// Randomised self-checking bench for sprite_renderer against a
// pixel-history reference model with a synchronous ROM model.
module tb_sprite_renderer;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        frame_start = 1'b0;
    logic [7:0]  Keycode = 8'd0;
    logic [10:0] spritex = 11'd0;
    logic [10:0] spritey = 11'd0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [13:0] rom_addr;
    logic [3:0]  rom_data = 4'd0;
    logic        sprite_on;
    logic [3:0]  pixel_idx;
    logic [3:0]  anim_frame;
    logic        facing_left;

    sprite_renderer dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .Keycode     (Keycode),
        .spritex     (spritex),
        .spritey     (spritey),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sprite_on   (sprite_on),
        .pixel_idx   (pixel_idx),
        .anim_frame  (anim_frame),
        .facing_left (facing_left)
    );

    always #5 Clk = ~Clk;

    logic [3:0] rom_mem [0:16383];

    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    bit       h_on [0:1023];
    bit [3:0] h_px [0:1023];
    int       exp_addr = 0;
    bit       m_walk = 0;
    int       m_wp = 0;
    bit       m_left = 0;

    function automatic int m_anim();
        return m_walk ? 8 + (m_wp / 8) % 4 : 8;
    endfunction

    function automatic bit e_on();
        return (cyc >= 3) ? h_on[(cyc - 3) % 1024] : 1'b0;
    endfunction

    function automatic bit [3:0] e_px();
        return (cyc >= 3) ? h_px[(cyc - 3) % 1024] : 4'd0;
    endfunction

    task automatic model_reset();
        m_walk   = 0;
        m_wp     = 0;
        m_left   = 0;
        exp_addr = 0;
    endtask

    task automatic tick(input bit fs);
        int dx, dy, sx, sy, col, row, addr;
        bit hit, kw;
        frame_start = fs;
        dx = DrawX; dy = DrawY; sx = spritex; sy = spritey;
        hit = Reset_n && dx >= sx && dx < sx + 32 &&
              dy >= sy && dy < sy + 32;
        col = dx - sx;
        row = dy - sy;
        if (m_left) col = 31 - col;
        addr = m_anim() * 1024 + row * 32 + col;
        h_on[cyc % 1024] = 0;
        h_px[cyc % 1024] = 0;
        if (hit) begin
            exp_addr = addr;
            if (rom_mem[addr] != 0) begin
                h_on[cyc % 1024] = 1;
                h_px[cyc % 1024] = rom_mem[addr];
            end
        end
        if (!Reset_n) model_reset();
        if (Reset_n && fs) begin
            kw = (Keycode == 79) || (Keycode == 80);
            if (!m_walk) begin
                if (kw) begin m_walk = 1; m_wp = 0; end
            end else if (kw) begin
                m_wp++;
            end else begin
                m_walk = 0; m_wp = 0;
            end
            if (Keycode == 80) m_left = 1;
            else if (Keycode == 79) m_left = 0;
        end
        @(posedge Clk);
        #1;
        cyc++;
        frame_start = 0;
    endtask

    task automatic test_reset();
        rom_mem[8192] = 4'd5;
        spritex = 11'd290; spritey = 11'd350;
        DrawX = 10'd290; DrawY = 10'd350;
        #2 Reset_n = 1'b0;
        for (int i = 0; i < 5; i++) tick(0);
        Reset_n = 1'b1;
        n_vec++;
        if (anim_frame !== 4'd8) begin
            n_err++;
            $display("FAIL reset_anim got %0d want 8", anim_frame);
        end
        n_vec++;
        if (facing_left !== 1'b0) begin
            n_err++;
            $display("FAIL reset_facing got %0b want 0", facing_left);
        end
        n_vec++;
        if (rom_addr !== 14'd0) begin
            n_err++;
            $display("FAIL reset_addr got %0d want 0", rom_addr);
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (sprite_on !== 1'b0) begin
                n_err++;
                $display("FAIL reset_on c%0d got %0b want 0",
                         i, sprite_on);
            end
            tick(0);
        end
        n_vec++;
        if (sprite_on !== 1'b1 || pixel_idx !== 4'd5) begin
            n_err++;
            $display("FAIL reset_first_hit got %0b/%0d want 1/5",
                     sprite_on, pixel_idx);
        end
    endtask

    task automatic test_hit_latency();
        Keycode = 8'd0;
        DrawX = 10'd290; DrawY = 10'd350;
        tick(0);
        n_vec++;
        if (rom_addr !== 14'd8192) begin
            n_err++;
            $display("FAIL hit_addr got %0d want 8192", rom_addr);
        end
        DrawX = 10'd322;
        tick(0);
        tick(0);
        n_vec++;
        if (sprite_on !== 1'b1 || pixel_idx !== 4'd5) begin
            n_err++;
            $display("FAIL hit_n3 got %0b/%0d want 1/5",
                     sprite_on, pixel_idx);
        end
        tick(0);
        n_vec++;
        if (sprite_on !== 1'b0 || pixel_idx !== 4'd0) begin
            n_err++;
            $display("FAIL hit_x322 got %0b/%0d want 0/0",
                     sprite_on, pixel_idx);
        end
        n_vec++;
        if (rom_addr !== 14'd8192) begin
            n_err++;
            $display("FAIL hit_hold_addr got %0d want 8192", rom_addr);
        end
    endtask

    task automatic test_mirror();
        Keycode = 8'd80;
        tick(1);
        n_vec++;
        if (facing_left !== 1'b1) begin
            n_err++;
            $display("FAIL mirror_facing got %0b want 1", facing_left);
        end
        DrawX = 10'd293; DrawY = 10'd350;
        tick(0);
        n_vec++;
        if (rom_addr !== 14'd8220) begin
            n_err++;
            $display("FAIL mirror_addr got %0d want 8220", rom_addr);
        end
        Keycode = 8'd0;
        tick(1);
        n_vec++;
        if (facing_left !== 1'b1) begin
            n_err++;
            $display("FAIL mirror_hold got %0b want 1", facing_left);
        end
    endtask

    task automatic test_walk();
        int want;
        Keycode = 8'd79;
        for (int p = 1; p <= 40; p++) begin
            tick(1);
            tick(0);
            want = -1;
            if (p == 1 || p == 33) want = 8;
            if (p == 9) want = 9;
            if (p == 17) want = 10;
            if (p == 25) want = 11;
            n_vec++;
            if (anim_frame !== 4'(m_anim()) ||
                (want >= 0 && anim_frame !== 4'(want))) begin
                n_err++;
                $display("FAIL walk_p%0d got %0d want %0d",
                         p, anim_frame, m_anim());
            end
        end
        n_vec++;
        if (facing_left !== 1'b0) begin
            n_err++;
            $display("FAIL walk_facing got %0b want 0", facing_left);
        end
        Keycode = 8'd0;
        tick(1);
        n_vec++;
        if (anim_frame !== 4'd8) begin
            n_err++;
            $display("FAIL walk_stop got %0d want 8", anim_frame);
        end
        Keycode = 8'd79;
        for (int p = 0; p < 9; p++) tick(1);
        n_vec++;
        if (anim_frame !== 4'd9) begin
            n_err++;
            $display("FAIL walk_restart got %0d want 9", anim_frame);
        end
        Keycode = 8'd0;
        tick(1);
    endtask

    task automatic test_edges();
        spritex = 11'd100; spritey = 11'd100;
        rom_mem[8192 + 0 * 32 + 4] = 4'd0;
        rom_mem[8192 + 31 * 32 + 4] = 4'd9;
        DrawX = 10'd104; DrawY = 10'd100;
        tick(0);
        DrawY = 10'd131;
        tick(0);
        DrawY = 10'd132;
        tick(0);
        n_vec++;
        if (sprite_on !== 1'b0 || pixel_idx !== 4'd0) begin
            n_err++;
            $display("FAIL edge_transparent got %0b/%0d want 0/0",
                     sprite_on, pixel_idx);
        end
        spritex = 11'd2040; DrawX = 10'd5; DrawY = 10'd110;
        tick(0);
        n_vec++;
        if (sprite_on !== 1'b1 || pixel_idx !== 4'd9) begin
            n_err++;
            $display("FAIL edge_row31 got %0b/%0d want 1/9",
                     sprite_on, pixel_idx);
        end
        tick(0);
        n_vec++;
        if (sprite_on !== 1'b0) begin
            n_err++;
            $display("FAIL edge_row32 got %0b want 0", sprite_on);
        end
        tick(0);
        n_vec++;
        if (sprite_on !== 1'b0) begin
            n_err++;
            $display("FAIL edge_x2040 got %0b want 0", sprite_on);
        end
    endtask

    task automatic test_midline_reset();
        spritex = 11'd100; spritey = 11'd100;
        rom_mem[8192 + 5] = 4'd7;
        DrawX = 10'd105; DrawY = 10'd100;
        for (int i = 0; i < 4; i++) tick(0);
        n_vec++;
        if (sprite_on !== 1'b1 || pixel_idx !== 4'd7) begin
            n_err++;
            $display("FAIL mid_before got %0b/%0d want 1/7",
                     sprite_on, pixel_idx);
        end
        #2 Reset_n = 1'b0;
        #1;
        for (int k = 1; k <= 3; k++) begin
            h_on[(cyc - k) % 1024] = 0;
            h_px[(cyc - k) % 1024] = 0;
        end
        model_reset();
        n_vec++;
        if (sprite_on !== 1'b0 || pixel_idx !== 4'd0 ||
            rom_addr !== 14'd0) begin
            n_err++;
            $display("FAIL mid_async got %0b/%0d/%0d want 0/0/0",
                     sprite_on, pixel_idx, rom_addr);
        end
        tick(0);
        tick(0);
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(0);
            n_vec++;
            if (sprite_on !== e_on() ||
                sprite_on !== (i == 2)) begin
                n_err++;
                $display("FAIL mid_refill c%0d got %0b want %0b",
                         i, sprite_on, e_on());
            end
        end
    endtask

    task automatic test_random();
        int kc;
        for (int i = 0; i < 1200; i++) begin
            if (i % 100 == 0) begin
                spritex = 11'($urandom_range(0, 660));
                spritey = 11'($urandom_range(0, 500));
            end
            if (i % 37 == 0) begin
                kc = $urandom_range(0, 3);
                Keycode = (kc == 0) ? 8'd79 : (kc == 1) ? 8'd80 :
                          (kc == 2) ? 8'd0 : 8'd4;
            end
            DrawX = 10'(int'(spritex) + $urandom_range(0, 40) - 4);
            DrawY = 10'(int'(spritey) + $urandom_range(0, 40) - 4);
            tick($urandom_range(0, 9) == 0);
            n_vec++;
            if (sprite_on !== e_on() || pixel_idx !== e_px()) begin
                n_err++;
                $display("FAIL rand_pix c%0d got %0b/%0d want %0b/%0d",
                         cyc, sprite_on, pixel_idx, e_on(), e_px());
            end
            n_vec++;
            if (rom_addr !== 14'(exp_addr)) begin
                n_err++;
                $display("FAIL rand_addr c%0d got %0d want %0d",
                         cyc, rom_addr, exp_addr);
            end
            n_vec++;
            if (anim_frame !== 4'(m_anim()) ||
                facing_left !== m_left) begin
                n_err++;
                $display("FAIL rand_anim c%0d got %0d/%0b want %0d/%0b",
                         cyc, anim_frame, facing_left, m_anim(), m_left);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++)
            rom_mem[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 1024; i++) begin
            h_on[i] = 0;
            h_px[i] = 0;
        end
        test_reset();
        test_hit_latency();
        test_mirror();
        test_walk();
        test_edges();
        test_midline_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
